// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences one layer's weights and biases from a word
// stream onto the shared layer configuration bus.
module weight_load_ctrl #(
  parameter int dataWidth = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          layer_num,
  input  logic [CNT_W-1:0]     neuron_count,
  input  logic [CNT_W-1:0]     weight_count,
  input  logic                 abort,
  input  logic [dataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num,
  output logic [dataWidth-1:0] weightValue,
  output logic                 weightValid,
  output logic [dataWidth-1:0] biasValue,
  output logic                 biasValid,
  output logic                 busy,
  output logic                 done,
  output logic                 start_err
);

  typedef enum logic [1:0] {
    IDLE,
    WEIGHT,
    BIAS
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          layer_q, layer_d;
  logic [CNT_W-1:0]     ncount_q, ncount_d;
  logic [CNT_W-1:0]     wcount_q, wcount_d;
  logic [CNT_W-1:0]     ncnt_q, ncnt_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]     nsel_q, nsel_d;
  logic [dataWidth-1:0] wval_q, wval_d;
  logic [dataWidth-1:0] bval_q, bval_d;
  logic                 wvld_q, wvld_d;
  logic                 bvld_q, bvld_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 serr_q, serr_d;
  logic                 xfer;
  logic [CNT_W-1:0]     wlast;
  logic [CNT_W-1:0]     nlast;

  assign in_ready = (state_q == WEIGHT || state_q == BIAS) & ~abort;
  assign xfer     = in_valid & in_ready;
  assign wlast    = wcount_q - CNT_W'(1);
  assign nlast    = ncount_q - CNT_W'(1);

  // Next-state, counter and bus-register logic.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    ncount_d = ncount_q;
    wcount_d = wcount_q;
    ncnt_d   = ncnt_q;
    wcnt_d   = wcnt_q;
    nsel_d   = nsel_q;
    wval_d   = wval_q;
    bval_d   = bval_q;
    wvld_d   = 1'b0;
    bvld_d   = 1'b0;
    done_d   = 1'b0;
    serr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          layer_d  = layer_num;
          ncount_d = neuron_count;
          wcount_d = weight_count;
          ncnt_d   = '0;
          wcnt_d   = '0;
          if (neuron_count == '0) begin
            done_d = 1'b1;
          end else if (weight_count == '0) begin
            state_d = BIAS;
          end else begin
            state_d = WEIGHT;
          end
        end
      end
      WEIGHT: begin
        serr_d = start;
        if (abort) begin
          state_d = IDLE;
          ncnt_d  = '0;
          wcnt_d  = '0;
        end else if (xfer) begin
          wval_d = in_data;
          wvld_d = 1'b1;
          nsel_d = ncnt_q;
          if (wcnt_q == wlast) begin
            state_d = BIAS;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
      end
      BIAS: begin
        serr_d = start;
        if (abort) begin
          state_d = IDLE;
          ncnt_d  = '0;
          wcnt_d  = '0;
        end else if (xfer) begin
          bval_d = in_data;
          bvld_d = 1'b1;
          nsel_d = ncnt_q;
          if (ncnt_q == nlast) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ncnt_d  = '0;
          end else begin
            ncnt_d  = ncnt_q + CNT_W'(1);
            state_d = (wcount_q == '0) ? BIAS : WEIGHT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      ncount_q <= '0;
      wcount_q <= '0;
      ncnt_q   <= '0;
      wcnt_q   <= '0;
      nsel_q   <= '0;
      wval_q   <= '0;
      bval_q   <= '0;
      wvld_q   <= 1'b0;
      bvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      ncount_q <= ncount_d;
      wcount_q <= wcount_d;
      ncnt_q   <= ncnt_d;
      wcnt_q   <= wcnt_d;
      nsel_q   <= nsel_d;
      wval_q   <= wval_d;
      bval_q   <= bval_d;
      wvld_q   <= wvld_d;
      bvld_q   <= bvld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      serr_q   <= serr_d;
    end
  end

  assign config_layer_num  = layer_q;
  assign config_neuron_num = 32'(nsel_q);
  assign weightValue       = wval_q;
  assign weightValid       = wvld_q;
  assign biasValue         = bval_q;
  assign biasValid         = bvld_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign start_err         = serr_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed and randomized checks of weight_load_ctrl
// against a transfer-index reference model.
module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [31:0] layer_num, in_data;
  logic [15:0] neuron_count, weight_count;
  logic        in_ready, weightValid, biasValid;
  logic        busy, done, start_err;
  logic [31:0] config_layer_num, config_neuron_num;
  logic [31:0] weightValue, biasValue;

  always #5 clk = ~clk;

  weight_load_ctrl #(.dataWidth(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .layer_num(layer_num), .neuron_count(neuron_count),
    .weight_count(weight_count), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num),
    .weightValue(weightValue), .weightValid(weightValid),
    .biasValue(biasValue), .biasValid(biasValid),
    .busy(busy), .done(done), .start_err(start_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a load is a flat list of nc*(wc+1) transfers; transfer k
  // goes to neuron k/(wc+1) and is the bias when k%(wc+1)==wc.
  bit          m_act = 1'b0;
  longint      m_k, m_total;
  int          m_wc;
  logic        e_wv, e_bv, e_busy, e_done, e_serr, e_rdy, o_rdy;
  logic [31:0] e_wval, e_bval, e_layer, e_nn;

  function automatic logic [132:0] obs_v();
    return {weightValid, weightValue, biasValid, biasValue,
            config_layer_num, config_neuron_num, busy, done, start_err};
  endfunction

  function automatic logic [132:0] exp_v();
    return {e_wv, e_wval, e_bv, e_bval, e_layer, e_nn,
            e_busy, e_done, e_serr};
  endfunction

  task automatic cycle(input bit r, input bit st, input logic [31:0] ln,
                       input logic [15:0] nc, input logic [15:0] wc,
                       input bit ab, input bit iv, input logic [31:0] d);
    longint pos;
    rst = r; start = st; layer_num = ln; neuron_count = nc;
    weight_count = wc; abort = ab; in_valid = iv; in_data = d;
    #1;
    o_rdy = in_ready;
    e_rdy = m_act & !ab;
    e_wv = 0; e_bv = 0; e_done = 0; e_serr = 0;
    if (r) begin
      m_act = 0; e_wval = 0; e_bval = 0; e_layer = 0; e_nn = 0;
    end else if (!m_act) begin
      if (st) begin
        e_layer = ln;
        m_wc = int'(wc);
        m_total = longint'(nc) * longint'(m_wc + 1);
        m_k = 0;
        if (nc == 0) e_done = 1;
        else m_act = 1;
      end
    end else begin
      e_serr = st;
      if (ab) begin
        m_act = 0;
      end else if (iv) begin
        pos = m_k % (m_wc + 1);
        e_nn = 32'(m_k / (m_wc + 1));
        if (pos == m_wc) begin e_bv = 1; e_bval = d; end
        else begin e_wv = 1; e_wval = d; end
        m_k++;
        if (m_k == m_total) begin m_act = 0; e_done = 1; end
      end
    end
    e_busy = m_act;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL reset in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL reset outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_basic();
    int nw = 0, nb = 0;
    cycle(0, 1, 2, 2, 3, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) cycle(0, 0, 0, 0, 0, 0, 1, 32'h10 + i);
      else cycle(0, 0, 0, 0, 0, 0, 0, $urandom);
      nw += int'(weightValid); nb += int'(biasValid);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL basic in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL basic outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
    n_chk++;
    if (nw !== 6 || nb !== 2) begin
      n_err++; $display("FAIL basic strobes w=%0d b=%0d exp 6/2", nw, nb);
    end
  endtask

  task automatic test_bias_only();
    int nw = 0, nb = 0;
    cycle(0, 1, 5, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cycle(0, 0, 0, 0, 0, 0, 1, 32'hA + i);
      else cycle(0, 0, 0, 0, 0, 0, 0, 0);
      nw += int'(weightValid); nb += int'(biasValid);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL bias_only in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL bias_only outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
    n_chk++;
    if (nw !== 0 || nb !== 3) begin
      n_err++; $display("FAIL bias_only strobes w=%0d b=%0d exp 0/3", nw, nb);
    end
  endtask

  task automatic test_empty();
    for (int i = 0; i < 4; i++) begin
      cycle(0, i == 0, 9, 0, 4, 0, 1, $urandom);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL empty in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL empty outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    bit iv;
    cycle(0, 1, 2, 2, 3, 0, 0, 0);
    for (int i = 0; i < 40 && sent < 10; i++) begin
      iv = (i % 4 == 0 || i % 4 == 3) && sent < 8;
      cycle(0, 0, 0, 0, 0, 0, iv, 32'h20 + sent);
      if (iv) sent++;
      else if (sent >= 8) sent++;
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL backpressure in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL backpressure outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_abort();
    int ns = 0;
    cycle(0, 1, 2, 2, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) cycle(0, 0, 0, 0, 0, 0, 1, 32'h30 + i);
      else if (i == 4) cycle(0, 0, 0, 0, 0, 1, 1, 32'h99);
      else if (i == 6) cycle(0, 1, 7, 1, 1, 0, 0, 0);
      else if (i == 7 || i == 8) cycle(0, 0, 0, 0, 0, 0, 1, 32'h40 + i);
      else cycle(0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 6) ns += int'(weightValid) + int'(biasValid);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL abort in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL abort outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
    n_chk++;
    if (ns !== 4) begin
      n_err++; $display("FAIL abort strobes obs=%0d exp=4", ns);
    end
  endtask

  task automatic test_start_err();
    cycle(0, 1, 3, 2, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 1) cycle(0, 1, 8, 5, 5, 0, 1, 32'h50 + i);
      else if (i == 6) cycle(0, 1, 4, 1, 1, 0, 0, 0);
      else if (i == 7) cycle(0, 1, 6, 1, 1, 1, 1, 32'h77);
      else cycle(0, 0, 0, 0, 0, 0, 1, 32'h50 + i);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL start_err in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL start_err outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 2, 2, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(i == 3, 0, 0, 0, 0, 0, i < 5, 32'h60 + i);
      n_chk += 2;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL reset_mid in_ready obs=%b exp=%b", o_rdy, e_rdy);
      end
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL reset_mid outputs obs=%h exp=%h", obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    bit st, ab, iv;
    for (int c = 0; c < 25; c++) begin
      cycle(0, 1, $urandom, 16'($urandom_range(0, 3)),
            16'($urandom_range(0, 3)), 0, 0, 0);
      for (int i = 0; i < 60 && (m_act || i < 2); i++) begin
        st = ($urandom_range(0, 15) == 0);
        ab = ($urandom_range(0, 39) == 0);
        iv = ($urandom_range(0, 3) != 0);
        cycle(0, st, $urandom, 16'($urandom_range(0, 3)),
              16'($urandom_range(0, 3)), ab, iv, $urandom);
        n_chk += 2;
        if (o_rdy !== e_rdy) begin
          n_err++; $display("FAIL random in_ready obs=%b exp=%b", o_rdy, e_rdy);
        end
        if (obs_v() !== exp_v()) begin
          n_err++; $display("FAIL random outputs obs=%h exp=%h", obs_v(), exp_v());
        end
      end
      n_chk++;
      if (m_act) begin
        n_err++; $display("FAIL random timeout cmd=%0d", c);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0;
    layer_num = 0; in_data = 0; neuron_count = 0; weight_count = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bias_only();
    test_empty();
    test_backpressure();
    test_abort();
    test_start_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequencer that loads weights and biases into the neuron array of one layer from a 32-bit word stream. Given a start command with layer number, neuron count and weights-per-neuron, it streams `weight_count` weights then one bias into each neuron in order. It drives the shared `config_layer_num` / `config_neuron_num` / `weightValue` / `weightValid` / `biasValue` / `biasValid` bus that all layers decode. It sits between the host-facing configuration path and the `Layer_N` instances, replacing per-word register pokes with one command per layer.

## Interface
- `dataWidth`, 32: width of stream words, weight and bias values.
- `CNT_W`, 16: width of neuron and weight counters and count inputs.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: command strobe, sampled in IDLE only.
- `layer_num` in 32: target layer, latched on accepted start.
- `neuron_count` in CNT_W: neurons to load, latched on accepted start.
- `weight_count` in CNT_W: weights per neuron, latched on accepted start.
- `abort` in 1: cancel the load in progress.
- `in_data` in dataWidth: stream word.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: controller accepts a word; combinational.
- `config_layer_num` out 32: layer select for the bus.
- `config_neuron_num` out 32: neuron select, zero-extended counter.
- `weightValue` out dataWidth: weight word.
- `weightValid` out 1: one-cycle weight write strobe.
- `biasValue` out dataWidth: bias word.
- `biasValid` out 1: one-cycle bias write strobe.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `start_err` out 1: one-cycle pulse when `start` arrives while not IDLE.

## Operation
- States:
  - IDLE: waits for a command.
  - WEIGHT: accepts weights for the current neuron.
  - BIAS: accepts the bias for the current neuron.
- Transfer: `in_valid & in_ready`.
- `in_ready = (state==WEIGHT || state==BIAS) & ~abort`.
- IDLE with `start`:
  - Latch the command and clear `neuron_cnt` and `weight_cnt`.
  - If `neuron_count==0`: stay IDLE, pulse `done` next cycle, issue no writes.
  - Else if `weight_count==0`: go to BIAS.
  - Else: go to WEIGHT.
- WEIGHT transfer:
  - Register `weightValue<=in_data`, `weightValid<=1`, `config_neuron_num<=neuron_cnt`.
  - `weight_cnt++`.
  - When `weight_cnt==weight_count-1`, go to BIAS and clear `weight_cnt`.
- BIAS transfer:
  - Register `biasValue<=in_data`, `biasValid<=1`, `config_neuron_num<=neuron_cnt`.
  - If `neuron_cnt==neuron_count-1`: go to IDLE and pulse `done`.
  - Else: `neuron_cnt++`, then go to WEIGHT, or stay in BIAS if `weight_count==0`.
- No transfer in a cycle: `weightValid` and `biasValid` are 0 the next cycle. `weightValue`, `biasValue` and `config_*` hold their values.
- `abort` in WEIGHT or BIAS: go to IDLE next cycle, no `done`, counters cleared. A strobe registered from the previous cycle's transfer still appears.
- `start` in WEIGHT or BIAS: ignored, and `start_err` pulses next cycle. When `start` and `abort` coincide, abort wins and `start_err` still pulses.
- `config_layer_num` is updated only on an accepted start.
- Counter compares use the latched counts. Counts up to 2^CNT_W-1 are legal, with no wrap inside a load.

## Timing
- Reset values:
  - `state=IDLE`, `in_ready=0`.
  - `weightValid=0`, `biasValid=0`, `busy=0`, `done=0`, `start_err=0`.
  - `weightValue=0`, `biasValue=0`, `config_layer_num=0`, `config_neuron_num=0`.
  - Counters 0.
- Command latency: `start` accepted at cycle t, then `busy=1` and `in_ready=1` at t+1.
- Write latency: word transferred at t, strobe at t+1. `config_layer_num` and `config_neuron_num` are valid in the same cycle as the strobe.
- Throughput: one word per cycle with `in_valid` held high. A load takes `neuron_count*(weight_count+1)` transfers.
- Completion: last bias transferred at t, then `biasValid=1`, `done=1`, `busy=0` at t+1. A new `start` is accepted at t+1.
- `busy` is registered: 1 exactly while the state is not IDLE.
- Reset mid-load: all outputs return to reset values next cycle. No partial `done`.

## Test plan
- Basic load:
  - Stimulus: `layer_num=2`, `neuron_count=2`, `weight_count=3`, words 0x10..0x17 back-to-back.
  - Response: `weightValid` with values 0x10,0x11,0x12 at neuron 0, then `biasValid` 0x13 at neuron 0, then the same pattern 0x14..0x17 at neuron 1.
  - `config_layer_num=2` throughout; `done` coincides with bias 0x17; `busy` low the same cycle.
- Bias-only load:
  - Stimulus: `weight_count=0`, `neuron_count=3`, words 0xA,0xB,0xC.
  - Response: three `biasValid` strobes at neurons 0,1,2, no `weightValid`, `done` with the third strobe.
- Empty command:
  - Stimulus: `neuron_count=0`.
  - Response: `done` one cycle after `start`, `busy` never high, no strobes.
- Backpressure gaps:
  - Stimulus: `in_valid` toggled 1,0,0,1 during the basic load.
  - Response: strobes only in the cycle after each transfer, same value order, `config_*` held during gaps.
- Abort mid-load:
  - Stimulus: assert `abort` after 4 transfers of the basic load.
  - Response: 4 strobes total, `in_ready` 0 in the abort cycle, IDLE next cycle, no `done`.
  - A subsequent `start` restarts at neuron 0.
- Error and reset:
  - Stimulus: `start` during a load.
  - Response: `start_err` pulse, load unaffected.
  - Stimulus: `rst` during a load.
  - Response: all outputs return to reset values next cycle, no `done`.
